// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: N-lane pipeline register with 2-entry skid buffer, cause-qualified flush and bubble counter
//   clk, rst                 clock, async active-high reset
//   flush, flush_cause       flush request; cause 1 = exception (clears), 0 = branch (no effect)
//   in_valid/in_ready        upstream handshake; in_ready is registered (~skid valid)
//   in_lane_vld, in_data     per-lane valid and packed payload of incoming entry
//   out_valid/out_ready      downstream handshake on head entry
//   out_lane_vld, out_data   head lane valids / payload, zero when no head
//   occupancy                entries held (0..2)
//   bubble_cnt               saturating count of cycles with out_ready & ~out_valid
module pipe_stage_buf #(
    parameter int LANES  = 2,
    parameter int DATA_W = 192,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    flush_cause,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_vld,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_vld,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        bubble_cnt
);
    localparam int W = LANES * DATA_W;
    logic             h_vld, s_vld;
    logic [LANES-1:0] h_lv, s_lv;
    logic [W-1:0]     h_data, s_data;
    logic             acc, pop, exc;
    assign acc          = in_valid & ~s_vld;
    assign pop          = h_vld & out_ready;
    assign exc          = flush & flush_cause;
    assign in_ready     = ~s_vld;
    assign out_valid    = h_vld;
    assign out_lane_vld = h_vld ? h_lv : '0;
    assign out_data     = h_vld ? h_data : '0;
    assign occupancy    = {s_vld, h_vld & ~s_vld};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_vld      <= 1'b0;
            s_vld      <= 1'b0;
            h_lv       <= '0;
            s_lv       <= '0;
            h_data     <= '0;
            s_data     <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_ready && !h_vld && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (exc) begin
                h_vld  <= 1'b0;
                s_vld  <= 1'b0;
                h_lv   <= '0;
                s_lv   <= '0;
                h_data <= '0;
                s_data <= '0;
            end else if (s_vld) begin
                // full: in_ready is low, only a pop can move the skid entry forward
                if (pop) begin
                    h_vld  <= 1'b1;
                    h_lv   <= s_lv;
                    h_data <= s_data;
                    s_vld  <= 1'b0;
                    s_lv   <= '0;
                    s_data <= '0;
                end
            end else if (h_vld && !pop) begin
                if (acc) begin
                    s_vld  <= 1'b1;
                    s_lv   <= in_lane_vld;
                    s_data <= in_data;
                end
            end else if (acc) begin
                // head empty or being popped this cycle
                h_vld  <= 1'b1;
                h_lv   <= in_lane_vld;
                h_data <= in_data;
            end else if (h_vld) begin
                h_vld  <= 1'b0;
                h_lv   <= '0;
                h_data <= '0;
            end
        end
    end
    assert property (@(posedge clk) disable iff (rst) s_vld |-> h_vld);
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed + random checks of pipe_stage_buf against a queue model
module tb_pipe_stage_buf;
    localparam int LANES = 2, DATA_W = 192, W = LANES * DATA_W;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, flush_cause = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [LANES-1:0] in_lane_vld = '0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, s_in_ready, s_out_valid;
    logic [LANES-1:0] out_lane_vld, s_out_lane_vld;
    logic [W-1:0] out_data, s_out_data;
    logic [1:0] occupancy, s_occupancy;
    logic [15:0] bubble_cnt;
    logic [1:0] s_bubble_cnt;
    int checks = 0, errors = 0;
    typedef struct packed { logic [LANES-1:0] lv; logic [W-1:0] d; } ent_t;
    ent_t q[$];
    int unsigned m_cnt = 0, m_cnt2 = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_vld(in_lane_vld), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
        .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt));

    pipe_stage_buf #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_lane_vld(in_lane_vld), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_lane_vld(s_out_lane_vld),
        .out_data(s_out_data), .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic v;
        logic [LANES-1:0] lv;
        logic [W-1:0] d;
        v  = q.size() > 0;
        lv = v ? q[0].lv : '0;
        d  = v ? q[0].d : '0;
        chk("out_valid", W'(out_valid), W'(v));
        chk("in_ready", W'(in_ready), W'(q.size() < 2));
        chk("occupancy", W'(occupancy), W'(q.size()));
        chk("out_lane_vld", W'(out_lane_vld), W'(lv));
        chk("out_data", out_data, d);
        chk("bubble_cnt", W'(bubble_cnt), W'(m_cnt));
        chk("sat_out_valid", W'(s_out_valid), W'(v));
        chk("sat_in_ready", W'(s_in_ready), W'(q.size() < 2));
        chk("sat_occupancy", W'(s_occupancy), W'(q.size()));
        chk("sat_out_lane_vld", W'(s_out_lane_vld), W'(lv));
        chk("sat_out_data", s_out_data, d);
        chk("sat_bubble_cnt", W'(s_bubble_cnt), W'(m_cnt2));
    endtask

    // check current outputs, advance the model by one edge with current inputs, then clock
    task automatic cyc();
        logic acc, pop;
        check_outs();
        if (out_ready && q.size() == 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        acc = in_valid && q.size() < 2;
        pop = q.size() > 0 && out_ready;
        if (flush && flush_cause) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{lv: in_lane_vld, d: in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [W-1:0] d, input logic [LANES-1:0] lv);
        in_valid = v; out_ready = r; in_data = d; in_lane_vld = lv;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #12;
        check_outs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        // streaming
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1, W'(k), 2'b11);
            cyc();
        end
        drive(1'b0, 1'b1, '0, '0);
        cyc();
        cyc();
        // backpressure: A, B then C held off, then release
        drive(1'b1, 1'b0, W'(32'hA), 2'b11); cyc();
        drive(1'b1, 1'b0, W'(32'hB), 2'b10); cyc();
        drive(1'b1, 1'b0, W'(32'hC), 2'b01); cyc(); cyc();
        chk("bp_in_ready", W'(in_ready), W'(0));
        drive(1'b1, 1'b1, W'(32'hC), 2'b01); cyc(); cyc();
        drive(1'b0, 1'b1, '0, '0); cyc(); cyc(); cyc();
        // exception flush with two entries and a pending input
        drive(1'b1, 1'b0, W'(32'h11), 2'b11); cyc();
        drive(1'b1, 1'b0, W'(32'h22), 2'b11); cyc();
        drive(1'b1, 1'b0, W'(32'h33), 2'b11);
        flush = 1'b1; flush_cause = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        chk("exc_occupancy", W'(occupancy), W'(0));
        chk("exc_out_data", out_data, '0);
        cyc();
        // branch flush with one entry and simultaneous pop + accept
        drive(1'b1, 1'b0, W'(32'h44), 2'b11); cyc();
        drive(1'b1, 1'b1, W'(32'h55), 2'b11);
        flush = 1'b1; flush_cause = 1'b0;
        cyc();
        flush = 1'b0;
        chk("br_occupancy", W'(occupancy), W'(1));
        drive(1'b0, 1'b1, '0, '0); cyc(); cyc();
        // lane mask then idle bubbles
        drive(1'b1, 1'b1, W'(32'h66), 2'b01); cyc();
        chk("mask_lane_vld", W'(out_lane_vld), W'(2'b01));
        drive(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 6; i++) cyc();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rnd_data(), 2'($urandom));
            flush = $urandom_range(0, 15) == 0;
            flush_cause = 1'($urandom);
            cyc();
        end
        flush = 1'b0;
        // async reset mid-cycle at occupancy 2, then counter saturation
        drive(1'b1, 1'b0, rnd_data(), 2'b11); cyc();
        drive(1'b1, 1'b0, rnd_data(), 2'b10); cyc();
        chk("pre_rst_occupancy", W'(occupancy), W'(2));
        drive(1'b0, 1'b0, '0, '0);
        #3 rst = 1'b1;
        #1;
        q.delete(); m_cnt = 0; m_cnt2 = 0;
        check_outs();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 6; i++) cyc();
        check_outs();
        chk("sat_stop", W'(s_bubble_cnt), W'(3));
        chk("cnt_six", W'(bubble_cnt), W'(6));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
